// File: rtl/sync_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package sync_mux_pkg;

    // Output register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Source encoding carried on addr and in the round-robin pointer.
    localparam logic PORT_X1 = 1'b0;
    localparam logic PORT_X2 = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sync_mux_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and its downstream sink.
interface sync_mux_arbiter_if
    import sync_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             x1_valid;
    logic [WIDTH-1:0] x1_data;
    logic             x1_ready;
    logic             x2_valid;
    logic [WIDTH-1:0] x2_data;
    logic             x2_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y;
    logic             y_ready;
    logic             addr;
    logic [CNT_W-1:0] cnt_x1;
    logic [CNT_W-1:0] cnt_x2;

    // Environment side: requesters and downstream consumer.
    modport master (
        output x1_valid, x1_data, x2_valid, x2_data, y_ready,
        input  x1_ready, x2_ready, y_valid, y, addr, cnt_x1, cnt_x2
    );

    // Arbiter side.
    modport slave (
        input  x1_valid, x1_data, x2_valid, x2_data, y_ready,
        output x1_ready, x2_ready, y_valid, y, addr, cnt_x1, cnt_x2
    );
endinterface

// File: rtl/sync_mux_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; the port that did not win last
// time gets priority on a tie. gnt is one-hot or zero.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);
    // On a tie, last=1 (x2 won last) favours x1 and vice versa.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = en & req[0] & (~req[1] | last);
        gnt[1] = en & req[1] & (~req[0] | ~last);
    end
endmodule

// File: rtl/sync_mux_arbiter.sv
// Round-robin arbiter feeding a registered 2:1 select, with per-port
// accepted-transfer counters.
module sync_mux_arbiter
    import sync_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                clr,
    sync_mux_arbiter_if.slave   bus
);
    out_state_e       state_q;
    logic [WIDTH-1:0] y_q;
    logic             addr_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_x1_q, cnt_x1_d;
    logic [CNT_W-1:0] cnt_x2_q, cnt_x2_d;
    logic [WIDTH-1:0] y_d;
    logic             full;
    logic             ld;
    logic             en;
    logic [1:0]       gnt;

    assign full     = (state_q == FULL);
    // The register can take a new word when empty or when its word leaves now.
    assign ld       = (state_q == EMPTY) | (full & bus.y_ready);
    // Readies stay low while reset is asserted.
    assign en       = ld & ~clr;
    assign cnt_x1_d = cnt_x1_q + CNT_W'(1);
    assign cnt_x2_d = cnt_x2_q + CNT_W'(1);
    assign y_d      = gnt[1] ? bus.x2_data : bus.x1_data;

    rr_pick2 u_pick (
        .req  ({bus.x2_valid, bus.x1_valid}),
        .last (last_q),
        .en   (en),
        .gnt  (gnt)
    );

    assign bus.x1_ready = gnt[0];
    assign bus.x2_ready = gnt[1];
    assign bus.y_valid  = full;
    assign bus.y        = y_q;
    assign bus.addr     = addr_q;
    assign bus.cnt_x1   = cnt_x1_q;
    assign bus.cnt_x2   = cnt_x2_q;

    // Output-stage FSM: load on grant, drain on consume without refill, else hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= EMPTY;
            y_q      <= '0;
            addr_q   <= PORT_X1;
            last_q   <= PORT_X2;
            cnt_x1_q <= '0;
            cnt_x2_q <= '0;
        end else if (gnt != 2'b00) begin
            state_q <= FULL;
            y_q     <= y_d;
            addr_q  <= gnt[1] ? PORT_X2 : PORT_X1;
            last_q  <= gnt[1] ? PORT_X2 : PORT_X1;
            if (gnt[0]) begin
                cnt_x1_q <= cnt_x1_d;
            end else begin
                cnt_x2_q <= cnt_x2_d;
            end
        end else if (full & bus.y_ready) begin
            state_q <= EMPTY;
        end
    end
endmodule

// File: tb/tb_sync_mux_arbiter.sv
// Scoreboard bench for sync_mux_arbiter: stimulus pushes expected words,
// a negedge monitor pops them as the sink consumes y.
module tb_sync_mux_arbiter;

    typedef struct packed {
        logic [7:0] y;
        logic       addr;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    sync_mux_arbiter_if #(.WIDTH(8), .CNT_W(16)) bus ();

    sync_mux_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] y, input logic a);
        exp_t e;
        e.y    = y;
        e.addr = a;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        chk("ready_x1_in_clr", {31'd0, bus.x1_ready}, 32'd0);
        chk("ready_x2_in_clr", {31'd0, bus.x2_ready}, 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        sb.delete();
    endtask

    // Monitor: every consumed word must match the oldest expectation.
    always @(negedge clk) begin
        if (!clr && bus.y_valid && bus.y_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_y", {24'd0, bus.y}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_y", {24'd0, bus.y}, {24'd0, e.y});
                chk("mon_addr", {31'd0, bus.addr}, {31'd0, e.addr});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.x1_valid = 1'b0;
        bus.x2_valid = 1'b0;
        bus.x1_data  = 8'h00;
        bus.x2_data  = 8'h00;
        bus.y_ready  = 1'b0;
        step();
        do_reset();
        chk("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
        chk("rst_y", {24'd0, bus.y}, 32'd0);
        chk("rst_addr", {31'd0, bus.addr}, 32'd0);
        chk("rst_cnt_x1", {16'd0, bus.cnt_x1}, 32'd0);
        chk("rst_cnt_x2", {16'd0, bus.cnt_x2}, 32'd0);

        // Single x1 word, then drain with no refill.
        bus.x1_valid = 1'b1;
        bus.x1_data  = 8'h5A;
        bus.y_ready  = 1'b1;
        #1;
        chk("t1_x1_ready", {31'd0, bus.x1_ready}, 32'd1);
        chk("t1_x2_ready", {31'd0, bus.x2_ready}, 32'd0);
        push(8'h5A, 1'b0);
        step();
        bus.x1_valid = 1'b0;
        chk("t1_y_valid", {31'd0, bus.y_valid}, 32'd1);
        chk("t1_y", {24'd0, bus.y}, 32'h5A);
        chk("t1_addr", {31'd0, bus.addr}, 32'd0);
        chk("t1_cnt_x1", {16'd0, bus.cnt_x1}, 32'd1);
        step();
        chk("drain_y_valid", {31'd0, bus.y_valid}, 32'd0);
        chk("drain_y_hold", {24'd0, bus.y}, 32'h5A);
        chk("drain_addr_hold", {31'd0, bus.addr}, 32'd0);

        // Continuous contention alternates starting with x1.
        bus.y_ready = 1'b0;
        do_reset();
        bus.x1_valid = 1'b1;
        bus.x1_data  = 8'h11;
        bus.x2_valid = 1'b1;
        bus.x2_data  = 8'h22;
        bus.y_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_x1_ready", {31'd0, bus.x1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_x2_ready", {31'd0, bus.x2_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) push(8'h11, 1'b0);
            else            push(8'h22, 1'b1);
            step();
        end
        bus.x1_valid = 1'b0;
        bus.x2_valid = 1'b0;
        chk("rr_cnt_x1", {16'd0, bus.cnt_x1}, 32'd3);
        chk("rr_cnt_x2", {16'd0, bus.cnt_x2}, 32'd3);
        step();

        // Stall with y held, then x2 accepted the cycle y_ready returns.
        bus.x1_valid = 1'b1;
        bus.x1_data  = 8'h33;
        bus.y_ready  = 1'b0;
        #1;
        chk("st_load_x1_ready", {31'd0, bus.x1_ready}, 32'd1);
        push(8'h33, 1'b0);
        step();
        bus.x1_valid = 1'b0;
        bus.x2_valid = 1'b1;
        bus.x2_data  = 8'h44;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("st_x1_ready", {31'd0, bus.x1_ready}, 32'd0);
            chk("st_x2_ready", {31'd0, bus.x2_ready}, 32'd0);
            chk("st_y", {24'd0, bus.y}, 32'h33);
            chk("st_y_valid", {31'd0, bus.y_valid}, 32'd1);
            step();
        end
        bus.y_ready = 1'b1;
        #1;
        chk("st_release_x2_ready", {31'd0, bus.x2_ready}, 32'd1);
        push(8'h44, 1'b1);
        step();
        bus.x2_valid = 1'b0;
        chk("st_y_next", {24'd0, bus.y}, 32'h44);
        chk("st_addr_next", {31'd0, bus.addr}, 32'd1);
        chk("st_cnt_x2", {16'd0, bus.cnt_x2}, 32'd4);
        step();
        chk("st_drained", {31'd0, bus.y_valid}, 32'd0);

        // Counter wrap on x2.
        bus.y_ready = 1'b0;
        do_reset();
        bus.x2_valid = 1'b1;
        bus.y_ready  = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.x2_data = i[7:0];
            push(i[7:0], 1'b1);
            step();
        end
        chk("wrap_pre", {16'd0, bus.cnt_x2}, 32'h0000_FFFF);
        bus.x2_data = 8'hEE;
        push(8'hEE, 1'b1);
        step();
        chk("wrap_post", {16'd0, bus.cnt_x2}, 32'd0);
        chk("wrap_cnt_x1", {16'd0, bus.cnt_x1}, 32'd0);
        bus.x2_valid = 1'b0;
        step();

        // Reset aborts a stalled word; x1 wins first after release.
        bus.x1_valid = 1'b1;
        bus.x1_data  = 8'h77;
        bus.y_ready  = 1'b0;
        push(8'h77, 1'b0);
        step();
        bus.x2_valid = 1'b1;
        bus.x1_data  = 8'hA1;
        bus.x2_data  = 8'hB2;
        chk("ab_full_before", {31'd0, bus.y_valid}, 32'd1);
        do_reset();
        chk("ab_y_valid", {31'd0, bus.y_valid}, 32'd0);
        chk("ab_y", {24'd0, bus.y}, 32'd0);
        chk("ab_addr", {31'd0, bus.addr}, 32'd0);
        chk("ab_cnt_x1", {16'd0, bus.cnt_x1}, 32'd0);
        chk("ab_cnt_x2", {16'd0, bus.cnt_x2}, 32'd0);
        bus.y_ready = 1'b1;
        #1;
        chk("ab_first_x1_ready", {31'd0, bus.x1_ready}, 32'd1);
        chk("ab_first_x2_ready", {31'd0, bus.x2_ready}, 32'd0);
        push(8'hA1, 1'b0);
        step();
        chk("ab_y_first", {24'd0, bus.y}, 32'hA1);
        #1;
        chk("ab_second_x2_ready", {31'd0, bus.x2_ready}, 32'd1);
        push(8'hB2, 1'b1);
        step();
        bus.x1_valid = 1'b0;
        bus.x2_valid = 1'b0;
        step();
        step();
        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_mux_arbiter.md
Name: sync_mux_arbiter

Overview:
- Two-requester round-robin arbiter wrapped around a registered 2:1 select.
- It owns the select address of the shared synchronous mux path. It also accepts valid/ready traffic from ports x1 and x2 and presents one registered stream downstream.
- It replaces free-running software control of addr with a fair, back-pressure-aware scheduler.
- It also keeps per-port transfer counters for bring-up visibility.

Parameters:
- WIDTH, 8: data width of x1, x2 and y.
- CNT_W, 16: width of the per-port accepted-transfer counters.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- clr  in  1  synchronous, active-high reset.
- x1_valid  in  1  requester 0 has data.
- x1_data  in  WIDTH  requester 0 payload.
- x1_ready  out  1  requester 0 payload accepted this cycle (when x1_valid is also high).
- x2_valid  in  1  requester 1 has data.
- x2_data  in  WIDTH  requester 1 payload.
- x2_ready  out  1  requester 1 payload accepted this cycle (when x2_valid is also high).
- y_valid  out  1  output register holds data.
- y  out  WIDTH  registered selected payload.
- y_ready  in  1  downstream consumes y this cycle.
- addr  out  1  source of current y: 0 = x1, 1 = x2; registered with y.
- cnt_x1  out  CNT_W  accepted x1 transfers, wraps.
- cnt_x2  out  CNT_W  accepted x2 transfers, wraps.

Behaviour:
- Reset (clr=1 at a clk edge) applies regardless of other inputs and aborts any held word:
  - y_valid=0, y=0, addr=0, cnt_x1=0, cnt_x2=0.
  - Round-robin pointer last=1, so x1 wins the first tie.
  - Ready outputs are low during the reset cycle.
- Output stage states:
  - EMPTY: y_valid=0.
  - FULL: y_valid=1.
- Load enable: ld = (state==EMPTY) | (y_valid & y_ready). This gives full throughput, one word per cycle under continuous y_ready.
- Grant, combinational:
  - Only x1_valid: grant x1.
  - Only x2_valid: grant x2.
  - Both valid: grant the port != last.
  - Neither valid: no grant.
- Ready outputs:
  - x1_ready = ld & grant==x1; x2_ready = ld & grant==x2.
  - At most one ready is high per cycle.
  - Ready never depends on the same port's valid beyond arbitration, so no combinational loop is created.
- On transfer from port p (p_valid & p_ready) at a clk edge:
  - y <= p_data, addr <= p, y_valid <= 1, last <= p, cnt_p <= cnt_p+1 mod 2^CNT_W.
- Drain without refill (y_valid & y_ready & no grant): y_valid <= 0; y and addr hold their last values.
- Stall (y_valid & !y_ready): y, addr and y_valid are held stable; x1_ready = x2_ready = 0. The AXI-style rule applies: y is not changed while y_valid & !y_ready.
- Latency: a word accepted at edge N appears on y/y_valid after edge N (visible in cycle N+1).
- Fairness: under continuous contention with y_ready=1, grants alternate x1, x2, x1, …; no port waits more than one transfer.
- Requesters must hold valid and data until ready; the block does not check this.
- Counter wrap: 0xFFFF + 1 -> 0x0000 with no saturation or flag.

Decomposition:
- Package sync_mux_pkg:
  - Output state enum {EMPTY, FULL}.
  - Constants PORT_X1=1'b0, PORT_X2=1'b1.
  - Default WIDTH/CNT_W localparams.
- Sub-module rr_pick2: purely combinational two-way round-robin picker. Inputs req[1:0], last, en; outputs gnt[1:0] (one-hot or zero).
- Top level holds the output register, pointer and counters.

Test Plan:
- Reset, then x1_valid=1, x1_data=0x5A, y_ready=1 -> x1_ready=1 in that cycle; next cycle y=0x5A, addr=0, y_valid=1; cnt_x1=1.
- Both valid continuously with x1_data=0x11 and x2_data=0x22, y_ready=1 for 6 cycles -> y sequence 0x11,0x22,0x11,0x22,0x11,0x22 with addr 0,1,0,1,0,1; cnt_x1=cnt_x2=3.
- y full with 0x33, y_ready=0 for 4 cycles while x2_valid=1 -> x1_ready=x2_ready=0; y stays 0x33, y_valid=1; y_ready=1 -> x2 accepted the same cycle; next y=x2_data.
- Word in y, y_ready=1, no valids -> y_valid drops to 0 next cycle; y and addr unchanged.
- Preload cnt_x2 to 0xFFFF via 65535 x2 transfers (or force), one more x2 transfer -> cnt_x2=0x0000.
- clr=1 asserted while y_valid=1, y_ready=0, both valid -> next cycle y_valid=0, y=0, addr=0, counters 0, readies low during clr. After release with both valid, x1 is granted first.
